// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width,
// and a two's complement negate helper.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Operates on 32 bits; callers truncate to their operand width, which
  // keeps the low bits correct for any width up to 32.
  function automatic logic [31:0] neg(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring iteration: shift {P,Q} left, then add or subtract D
// depending on the sign P had before the shift.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_p,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_p,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_d_ext;
  logic [WIDTH:0] w_sum;

  assign w_shift = {i_p[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_d_ext = {1'b0, i_d};
  assign w_sum   = i_p[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);

  assign o_p = w_sum;
  assign o_q = {i_q[WIDTH-2:0], ~w_sum[WIDTH]};

endmodule

// File: rtl/booth_divider.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's complement operands; default build is unsigned.
module booth_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_By_Zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_div0;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_res;
  logic [WIDTH-1:0] w_rem_res;

  assign w_div0 = (Divisor == '0);

`ifdef DIV_SIGNED_EN
  logic r_sign_a;
  logic r_sign_b;

  // |most-negative| is 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign w_mag_a = Dividend[WIDTH-1] ? WIDTH'(neg(32'(Dividend))) : Dividend;
  assign w_mag_b = Divisor[WIDTH-1]  ? WIDTH'(neg(32'(Divisor)))  : Divisor;
  assign w_quot_res = (r_sign_a ^ r_sign_b) ? WIDTH'(neg(32'(r_q))) : r_q;
  assign w_rem_res  = r_sign_a ? WIDTH'(neg(32'(w_rem_mag))) : w_rem_mag;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (r_state == S_IDLE && Start) begin
      r_sign_a <= Dividend[WIDTH-1];
      r_sign_b <= Divisor[WIDTH-1];
    end
  end
`else
  assign w_mag_a    = Dividend;
  assign w_mag_b    = Divisor;
  assign w_quot_res = r_q;
  assign w_rem_res  = w_rem_mag;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p (r_p),
    .i_q (r_q),
    .i_d (r_d),
    .o_p (w_p_nxt),
    .o_q (w_q_nxt)
  );

  // Final restore: a negative partial remainder gets D added back once.
  assign w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d) : r_p[WIDTH-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start) w_next = w_div0 ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_p    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_p   <= '0;
            r_q   <= w_mag_a;
            r_d   <= w_mag_b;
            r_cnt <= '0;
            r_dbz <= w_div0;
            if (w_div0) begin
              r_quot <= '1;
              r_rem  <= Dividend;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_quot <= w_quot_res;
          r_rem  <= w_rem_res;
        end
        default: ;
      endcase
    end
  end

  assign Busy        = (r_state != S_IDLE);
  assign Done        = (r_state == S_DONE);
  assign Quotient    = r_quot;
  assign Remainder   = r_rem;
  assign Div_By_Zero = r_dbz;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: driver pushes expected results, a
// negedge monitor pops and compares on every Done.
module tb_booth_divider;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Busy, Done, Div_By_Zero;
  logic [W-1:0] Quotient, Remainder;

  booth_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
    .Div_By_Zero(Div_By_Zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sb_;
      sa  = $signed(a);
      sb_ = $signed(b);
      q = W'(sa / sb_);
      r = W'(sa % sb_);
`else
      q = W'(int'(a) / int'(b));
      r = W'(int'(a) % int'(b));
`endif
      z = 1'b0;
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && Done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(Quotient), 32'(e.q));
        chk("remainder", 32'(Remainder), 32'(e.r));
        chk("div_by_zero", 32'(Div_By_Zero), 32'(e.z));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issues one request; stray=1 pulses Start at relative cycles 2 and 6.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit stray);
    exp_t e;
    int   c, lat, base;
    @(negedge Clk);
    c = cyc;
    lat = (b == '0) ? 1 : W + 2;
    Start = 1'b1; Dividend = a; Divisor = b;
    model(a, b, e.q, e.r, e.z);
    e.cyc = c + lat;
    sb.push_back(e);
    base = done_cnt;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge Clk);
      Start = stray && (k == 2 || k == 6);
      Dividend = W'($urandom);
      Divisor  = W'($urandom);
      if (k == 1) chk("dbz_after_accept", 32'(Div_By_Zero), 32'(b == '0));
      if (k <= lat) chk("busy_high", 32'(Busy), 32'd1);
      else          chk("busy_low_after_done", 32'(Busy), 32'd0);
    end
    Start = 1'b0;
    if (stray) repeat (W + 4) @(negedge Clk);
    chk("done_count", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic reset_abort();
    int base;
    @(negedge Clk);
    base = done_cnt;
    Start = 1'b1; Dividend = W'(7); Divisor = W'(2);
    repeat (3) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    // Reset sampled at the end of cycle 3; the simultaneous Start must be ignored.
    Reset = 1'b1; Start = 1'b1; Dividend = W'(6); Divisor = W'(3);
    @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_quot", 32'(Quotient), 32'd0);
    chk("rst_rem", 32'(Remainder), 32'd0);
    chk("rst_dbz", 32'(Div_By_Zero), 32'd0);
    Reset = 1'b0; Start = 1'b0;
    repeat (W + 6) @(negedge Clk);
    chk("no_done_after_abort", 32'(done_cnt - base), 32'd0);
    chk("idle_after_abort", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_quot", 32'(Quotient), 32'd0);
    chk("reset_rem", 32'(Remainder), 32'd0);
    chk("reset_dbz", 32'(Div_By_Zero), 32'd0);
    Reset = 1'b0;

`ifdef DIV_SIGNED_EN
    run_op(4'd7, 4'd2, 1'b0);
    run_op(4'b1001, 4'd2, 1'b0);
    run_op(4'd7, 4'b1110, 1'b0);
    run_op(4'd5, 4'd0, 1'b0);
    run_op(4'd7, 4'd2, 1'b0);
    run_op(4'b1000, 4'b1111, 1'b0);
    run_op(4'b1000, 4'd1, 1'b0);
`else
    run_op(4'd7, 4'd2, 1'b0);
    run_op(4'd15, 4'd4, 1'b0);
    run_op(4'd5, 4'd0, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0, 4'd1, 1'b0);
    run_op(4'd1, 4'd15, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
`endif
    run_op(4'd7, 4'd2, 1'b1);
    reset_abort();
    run_op(4'd6, 4'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(a, b, 1'b0);
    end

    repeat (4) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
